// File: rtl/i2s_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : i2s_pkg                                                  |
// | Description : Shared state encodings and constants for the I2S ADC     |
// |               capture path.                                            |
// | Revision    : 1.0 - initial release                                    |
// +-----------------------------------------------------------------------+
package i2s_pkg;

  // Capture FSM states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    CAP_L  = 3'd2,
    WAIT_R = 3'd3,
    CAP_R  = 3'd4,
    WAIT_L = 3'd5
  } state_t;

  // Bits captured per channel unless overridden
  localparam int DEFAULT_SAMPLE_W = 16;

  // LRCK level that marks the left channel slot
  localparam logic LRCK_LEFT = 1'b0;

endpackage
`default_nettype wire

// File: rtl/i2s_adc_receiver_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : sync_fifo                                                |
// | Description : Single-clock show-ahead FIFO with registered head        |
// |               output. Push on a full FIFO is accepted only when a pop  |
// |               happens in the same cycle.                               |
// | Revision    : 1.0 - initial release                                    |
// +-----------------------------------------------------------------------+
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      rd_ptr_nxt;
  logic             do_push;
  logic             do_pop;
  logic [WIDTH-1:0] head_nxt;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = rd_en && !empty;
  assign do_push = wr_en && (!full || do_pop);

  // Next head: the incoming word if it lands on the new read slot, else storage
  always_comb begin
    rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, do_pop};
    head_nxt   = mem[rd_ptr_nxt[AW-1:0]];
    if (do_push && (wr_ptr[AW-1:0] == rd_ptr_nxt[AW-1:0])) begin
      head_nxt = wr_data;
    end
  end

  // Storage array write port
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  // Pointers and registered head word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      rd_ptr  <= rd_ptr_nxt;
      rd_data <= head_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2s_adc_receiver.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : i2s_adc_receiver                                         |
// | Description : Oversampled I2S slave receiver for the codec ADC. Syncs  |
// |               the codec pins, deserializes MSB-first stereo words and  |
// |               queues L/R pairs for a valid/ready consumer.             |
// | Revision    : 1.0 - initial release                                    |
// +-----------------------------------------------------------------------+
module i2s_adc_receiver
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W   = DEFAULT_SAMPLE_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clkin_50,
  input  logic                rst_n,
  input  logic                aud_bclk,
  input  logic                aud_adc_lrck,
  input  logic                aud_adc_dat,
  input  logic                enable,
  input  logic                sample_ready,
  output logic                sample_valid,
  output logic [SAMPLE_W-1:0] sample_left,
  output logic [SAMPLE_W-1:0] sample_right,
  input  logic                clr_status,
  output logic                overflow,
  output logic                misalign
);

  localparam int               CNT_W    = $clog2(SAMPLE_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SAMPLE_W - 1);

  // Synchronizer chains: bit 0 is the metastability stage, bit 1 the synced value
  logic [1:0] bclk_sr;
  logic [1:0] lrck_sr;
  logic [1:0] dat_sr;
  logic       bclk_d;
  logic       lrck_prev;
  logic       bclk_rise;
  logic       boundary;

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    bit_cnt;
  logic [SAMPLE_W-1:0] left_sr;
  logic [SAMPLE_W-1:0] right_sr;

  logic shift_l;
  logic shift_r;
  logic cnt_clr;
  logic cnt_inc;
  logic push;
  logic set_misalign;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  drop;
  logic [2*SAMPLE_W-1:0] push_data;
  logic [2*SAMPLE_W-1:0] head_data;

  // Two-flop synchronizers plus the bclk edge register
  always_ff @(posedge clkin_50 or negedge rst_n) begin
    if (!rst_n) begin
      bclk_sr <= '0;
      lrck_sr <= '0;
      dat_sr  <= '0;
      bclk_d  <= 1'b0;
    end else begin
      bclk_sr <= {bclk_sr[0], aud_bclk};
      lrck_sr <= {lrck_sr[0], aud_adc_lrck};
      dat_sr  <= {dat_sr[0], aud_adc_dat};
      bclk_d  <= bclk_sr[1];
    end
  end

  assign bclk_rise = bclk_sr[1] & ~bclk_d;
  assign boundary  = bclk_rise && (lrck_sr[1] != lrck_prev);

  // Track LRCK at every bit clock, even when idle, so that boundary
  // detection right after enable never sees a stale reference level
  always_ff @(posedge clkin_50 or negedge rst_n) begin
    if (!rst_n) begin
      lrck_prev <= 1'b0;
    end else if (bclk_rise) begin
      lrck_prev <= lrck_sr[1];
    end
  end

  // FSM state register
  always_ff @(posedge clkin_50 or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state and datapath strobes
  always_comb begin
    state_nxt    = state;
    shift_l      = 1'b0;
    shift_r      = 1'b0;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    push         = 1'b0;
    set_misalign = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_nxt = SYNC;
      end
      SYNC: begin
        if (boundary && (lrck_sr[1] == LRCK_LEFT)) begin
          cnt_clr   = 1'b1;
          state_nxt = CAP_L;
        end
      end
      CAP_L: begin
        if (boundary) begin
          set_misalign = 1'b1;
          state_nxt    = SYNC;
        end else if (bclk_rise) begin
          shift_l = 1'b1;
          if (bit_cnt == LAST_BIT) state_nxt = WAIT_R;
          else                     cnt_inc   = 1'b1;
        end
      end
      WAIT_R: begin
        if (boundary && (lrck_sr[1] != LRCK_LEFT)) begin
          cnt_clr   = 1'b1;
          state_nxt = CAP_R;
        end
      end
      CAP_R: begin
        if (boundary) begin
          set_misalign = 1'b1;
          state_nxt    = SYNC;
        end else if (bclk_rise) begin
          shift_r = 1'b1;
          if (bit_cnt == LAST_BIT) begin
            push      = 1'b1;
            state_nxt = WAIT_L;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      WAIT_L: begin
        if (boundary && (lrck_sr[1] == LRCK_LEFT)) begin
          cnt_clr   = 1'b1;
          state_nxt = CAP_L;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Disabling abandons any partial pair on the next cycle
    if (!enable) begin
      state_nxt    = IDLE;
      shift_l      = 1'b0;
      shift_r      = 1'b0;
      cnt_clr      = 1'b0;
      cnt_inc      = 1'b0;
      push         = 1'b0;
      set_misalign = 1'b0;
    end
  end

  // Bit counter and MSB-first shift registers
  always_ff @(posedge clkin_50 or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      left_sr  <= '0;
      right_sr <= '0;
    end else begin
      if (cnt_clr)      bit_cnt <= '0;
      else if (cnt_inc) bit_cnt <= bit_cnt + CNT_W'(1);
      if (shift_l) left_sr  <= {left_sr[SAMPLE_W-2:0], dat_sr[1]};
      if (shift_r) right_sr <= {right_sr[SAMPLE_W-2:0], dat_sr[1]};
    end
  end

  // The last right bit is still on the synced data line during the push cycle
  assign push_data = {left_sr, right_sr[SAMPLE_W-2:0], dat_sr[1]};

  // A push is lost only when the FIFO is full and nothing leaves this cycle
  assign drop = push && fifo_full && !(sample_valid && sample_ready);

  // Sticky status flags; a new event outranks a simultaneous clear
  always_ff @(posedge clkin_50 or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      misalign <= 1'b0;
    end else begin
      if (drop)            overflow <= 1'b1;
      else if (clr_status) overflow <= 1'b0;
      if (set_misalign)    misalign <= 1'b1;
      else if (clr_status) misalign <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (2 * SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clkin_50),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (push_data),
    .rd_en   (sample_ready),
    .rd_data (head_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign sample_valid = !fifo_empty;
  assign sample_left  = head_data[2*SAMPLE_W-1:SAMPLE_W];
  assign sample_right = head_data[SAMPLE_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_i2s_adc_receiver.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : tb_i2s_adc_receiver                                      |
// | Description : Scoreboard bench for i2s_adc_receiver with an I2S codec  |
// |               master model (32 bit slots, 16 bit words).               |
// | Revision    : 1.0 - initial release                                    |
// +-----------------------------------------------------------------------+
module tb_i2s_adc_receiver;

  localparam int SW   = 16;
  localparam int SLOT = 32;
  localparam int HALF = 8;   // bclk half period in clkin_50 cycles

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          aud_bclk = 1'b0;
  logic          aud_adc_lrck = 1'b1;
  logic          aud_adc_dat = 1'b0;
  logic          enable = 1'b0;
  logic          sample_ready = 1'b0;
  logic          clr_status = 1'b0;
  logic          sample_valid;
  logic [SW-1:0] sample_left;
  logic [SW-1:0] sample_right;
  logic          overflow;
  logic          misalign;

  int checks = 0;
  int errors = 0;
  int valid_hi = 0;
  logic [2*SW-1:0] exp_q [$];

  i2s_adc_receiver #(
    .SAMPLE_W   (SW),
    .FIFO_DEPTH (4)
  ) dut (
    .clkin_50     (clk),
    .rst_n        (rst_n),
    .aud_bclk     (aud_bclk),
    .aud_adc_lrck (aud_adc_lrck),
    .aud_adc_dat  (aud_adc_dat),
    .enable       (enable),
    .sample_ready (sample_ready),
    .sample_valid (sample_valid),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .clr_status   (clr_status),
    .overflow     (overflow),
    .misalign     (misalign)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // One bclk period: pins change with bclk low, codec-style. When hook is set,
  // sample_ready is pulsed for the single cycle in which this rising edge pushes.
  task automatic bclk_period(input logic lr, input logic d, input bit hook);
    aud_bclk     = 1'b0;
    aud_adc_lrck = lr;
    aud_adc_dat  = d;
    wait_cyc(HALF);
    aud_bclk = 1'b1;
    if (hook) begin
      wait_cyc(2);
      sample_ready = 1'b1;
      wait_cyc(1);
      sample_ready = 1'b0;
      wait_cyc(HALF - 3);
    end else begin
      wait_cyc(HALF);
    end
  endtask

  // A channel slot: period 0 is the one-bit delay, the word follows MSB first
  task automatic drive_slot(input logic lr, input logic [SW-1:0] word, input int nper, input bit hook);
    logic d;
    for (int k = 0; k < nper; k++) begin
      d = (k >= 1 && k <= SW) ? word[SW-k] : 1'b0;
      bclk_period(lr, d, hook && (k == SW));
    end
  endtask

  task automatic send_frame(input logic [SW-1:0] l, input logic [SW-1:0] r, input bit expect_it, input bit hook);
    if (expect_it) exp_q.push_back({l, r});
    drive_slot(1'b0, l, SLOT, 1'b0);
    drive_slot(1'b1, r, SLOT, hook);
  endtask

  task automatic pulse_clr();
    clr_status = 1'b1;
    wait_cyc(1);
    clr_status = 1'b0;
    wait_cyc(1);
  endtask

  // Consumer side: every accepted pair is compared with the scoreboard head
  always @(negedge clk) begin
    if (rst_n && sample_valid) valid_hi++;
    if (rst_n && sample_valid && sample_ready) begin
      if (exp_q.size() == 0) begin
        check("pop_with_nothing_expected", 48'(exp_q.size()), 48'd1);
      end else begin
        check("pair", {16'h0, sample_left, sample_right}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    // Reset values
    wait_cyc(3);
    check("rst_valid", 48'(sample_valid), 48'd0);
    check("rst_left", 48'(sample_left), 48'd0);
    check("rst_right", 48'(sample_right), 48'd0);
    check("rst_overflow", 48'(overflow), 48'd0);
    check("rst_misalign", 48'(misalign), 48'd0);
    rst_n = 1'b1;
    wait_cyc(2);

    // Basic frame
    enable       = 1'b1;
    sample_ready = 1'b1;
    drive_slot(1'b1, 16'h0000, SLOT, 1'b0);
    base = valid_hi;
    send_frame(16'hA5C3, 16'h3C5A, 1'b1, 1'b0);
    check("basic_valid_cycles", 48'(valid_hi - base), 48'd1);

    // Enable raised in the middle of a right slot
    enable = 1'b0;
    wait_cyc(2);
    drive_slot(1'b0, 16'hDEAD, SLOT, 1'b0);
    drive_slot(1'b1, 16'hBEEF, 10, 1'b0);
    enable = 1'b1;
    drive_slot(1'b1, 16'hBEEF, SLOT - 10, 1'b0);
    send_frame(16'h1234, 16'h5678, 1'b1, 1'b0);

    // Short left word
    check("pre_short_misalign", 48'(misalign), 48'd0);
    drive_slot(1'b0, 16'hFFFF, 11, 1'b0);
    drive_slot(1'b1, 16'h7777, SLOT, 1'b0);
    check("short_misalign", 48'(misalign), 48'd1);
    send_frame(16'h8001, 16'h7FFE, 1'b1, 1'b0);
    check("short_misalign_held", 48'(misalign), 48'd1);
    pulse_clr();
    check("short_misalign_clr", 48'(misalign), 48'd0);

    // Backpressure: six frames with no consumer, only the first four fit
    sample_ready = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      send_frame(16'(n), ~16'(n), n <= 4, 1'b0);
    end
    check("bp_overflow", 48'(overflow), 48'd1);
    check("bp_valid", 48'(sample_valid), 48'd1);
    check("bp_head_left", 48'(sample_left), 48'h0001);
    check("bp_head_right", 48'(sample_right), 48'hFFFE);
    sample_ready = 1'b1;
    wait_cyc(10);
    check("bp_drained", 48'(exp_q.size()), 48'd0);
    check("bp_empty", 48'(sample_valid), 48'd0);
    pulse_clr();
    check("bp_overflow_clr", 48'(overflow), 48'd0);
    for (int n = 7; n <= 8; n++) begin
      send_frame(16'(n), ~16'(n), 1'b1, 1'b0);
    end

    // Full FIFO: a pop in the exact push cycle makes room for the new pair
    sample_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      send_frame(16'h1000 + 16'(i), 16'h2000 + 16'(i), 1'b1, 1'b0);
    end
    send_frame(16'h1005, 16'h2005, 1'b1, 1'b1);
    check("full_overflow", 48'(overflow), 48'd0);
    check("full_head_left", 48'(sample_left), 48'h1002);
    check("full_pending", 48'(exp_q.size()), 48'd4);
    sample_ready = 1'b1;
    wait_cyc(10);
    check("full_drained", 48'(exp_q.size()), 48'd0);
    check("full_empty", 48'(sample_valid), 48'd0);

    // Reset mid right word with a pair already queued
    sample_ready = 1'b0;
    send_frame(16'h1111, 16'h2222, 1'b0, 1'b0);
    check("prerst_valid", 48'(sample_valid), 48'd1);
    drive_slot(1'b0, 16'h3333, SLOT, 1'b0);
    drive_slot(1'b1, 16'h4444, 6, 1'b0);
    rst_n = 1'b0;
    #3;
    check("midrst_valid", 48'(sample_valid), 48'd0);
    check("midrst_left", 48'(sample_left), 48'd0);
    check("midrst_right", 48'(sample_right), 48'd0);
    check("midrst_flags", {46'd0, overflow, misalign}, 48'd0);
    wait_cyc(1);
    rst_n        = 1'b1;
    sample_ready = 1'b1;
    drive_slot(1'b1, 16'h4444, SLOT - 6, 1'b0);
    send_frame(16'h5555, 16'h6666, 1'b1, 1'b0);
    wait_cyc(4);
    check("final_sb_empty", 48'(exp_q.size()), 48'd0);
    check("final_misalign", 48'(misalign), 48'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
